mymult_pipe: RTL and testbench

MYMULT_PIPE -- requirements
Module: mymult_pipe

---
 rtl/mymult_pipe.sv | 116 +++++++++++
 tb/tb_mymult_pipe.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mymult_pipe.sv
// Signed fixed-point multiplier with rescaling, optional rounding/saturation,
// a configurable-depth enable-gated output pipeline and a sticky overflow flag.
module mymult_pipe #(
  parameter int a_bits     = 8,
  parameter int a_point    = 4,
  parameter int b_bits     = 8,
  parameter int b_point    = 4,
  parameter int c_bits     = 8,
  parameter int c_point    = 4,
  parameter int stages     = 2,
  parameter int round_mode = 0,
  parameter int sat_mode   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic signed [a_bits-1:0] a,
  input  logic signed [b_bits-1:0] b,
  input  logic                     clr_ovf,
  output logic signed [c_bits-1:0] c,
  output logic                     out_valid,
  output logic                     ovf,
  output logic                     ovf_sticky
);

  localparam int P   = a_bits + b_bits;
  localparam int RSH = a_point + b_point - c_point;
  localparam int LSH = (RSH < 0) ? -RSH : 0;
  localparam int W0  = P + 1 + LSH;
  localparam int W   = (W0 > c_bits + 1) ? W0 : c_bits + 1;

  localparam logic [c_bits-1:0] C_MAX = {1'b0, {(c_bits-1){1'b1}}};
  localparam logic [c_bits-1:0] C_MIN = {1'b1, {(c_bits-1){1'b0}}};

  logic signed [P-1:0]      w_prod;
  logic signed [W-1:0]      w_ext;
  logic signed [W-1:0]      w_sh;
  logic [W-c_bits:0]        w_hi;
  logic                     w_ovf;
  logic [c_bits-1:0]        w_c;

  assign w_prod = a * b;
  assign w_ext  = {{(W-P){w_prod[P-1]}}, w_prod};

  // Rounding constant is added one bit wider than the product so it cannot wrap
  generate
    if (RSH > 0) begin : g_rsh
      localparam logic [W-1:0] RND = (round_mode == 1) ?
                                     ({{(W-1){1'b0}}, 1'b1} << (RSH-1)) : {W{1'b0}};
      assign w_sh = (w_ext + $signed(RND)) >>> RSH;
    end else if (RSH < 0) begin : g_lsh
      assign w_sh = w_ext <<< LSH;
    end else begin : g_pass
      assign w_sh = w_ext;
    end
  endgenerate

  // In range only when every bit from the c sign bit upward matches
  assign w_hi  = w_sh[W-1:c_bits-1];
  assign w_ovf = ~((&w_hi) | ~(|w_hi));
  assign w_c   = (w_ovf && (sat_mode == 1)) ? (w_sh[W-1] ? C_MIN : C_MAX)
                                            : w_sh[c_bits-1:0];

  logic [c_bits-1:0] r_c [stages];
  logic              r_v [stages];
  logic              r_o [stages];
  logic [c_bits-1:0] w_d_c [stages];
  logic              w_d_v [stages];
  logic              w_d_o [stages];
  logic              w_nxt_v;
  logic              w_nxt_o;
  logic              r_sticky;

  always_comb begin
    w_d_c[0] = w_c;
    w_d_v[0] = in_valid;
    w_d_o[0] = w_ovf;
    for (int i = 1; i < stages; i++) begin
      w_d_c[i] = r_c[i-1];
      w_d_v[i] = r_v[i-1];
      w_d_o[i] = r_o[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < stages; i++) begin
        r_c[i] <= '0;
        r_v[i] <= 1'b0;
        r_o[i] <= 1'b0;
      end
    end else if (en) begin
      for (int i = 0; i < stages; i++) begin
        r_c[i] <= w_d_c[i];
        r_v[i] <= w_d_v[i];
        r_o[i] <= w_d_o[i];
      end
    end
  end

  // Sticky looks at the output stage as it will be after this edge
  assign w_nxt_v = en ? w_d_v[stages-1] : r_v[stages-1];
  assign w_nxt_o = en ? w_d_o[stages-1] : r_o[stages-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sticky <= 1'b0;
    else     r_sticky <= (w_nxt_v & w_nxt_o) | (r_sticky & ~clr_ovf);
  end

  assign c          = r_c[stages-1];
  assign out_valid  = r_v[stages-1];
  assign ovf        = r_o[stages-1];
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_mymult_pipe.sv
// Directed bench: three configurations (saturate/truncate, wrap/truncate,
// saturate/round) share stimulus; expected values are hand-computed.
module tb_mymult_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       clr_ovf = 1'b0;

  logic [7:0] s_c, w_c, r_c;
  logic       s_v, w_v, r_v, s_o, w_o, r_o, s_st, w_st, r_st;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mymult_pipe u_sat (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a), .b(b),
    .clr_ovf(clr_ovf), .c(s_c), .out_valid(s_v), .ovf(s_o), .ovf_sticky(s_st));

  mymult_pipe #(.sat_mode(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a), .b(b),
    .clr_ovf(clr_ovf), .c(w_c), .out_valid(w_v), .ovf(w_o), .ovf_sticky(w_st));

  mymult_pipe #(.round_mode(1)) u_rnd (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a), .b(b),
    .clr_ovf(clr_ovf), .c(r_c), .out_valid(r_v), .ovf(r_o), .ovf_sticky(r_st));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                     input logic [7:0] ec_sat, input logic eovf,
                     input logic [7:0] ec_wrap, input logic [7:0] ec_rnd);
    a = ia; b = ib; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_lat_v"}, {7'd0, s_v}, 8'd0);
    step();
    chk({tag, "_sat_c"}, s_c, ec_sat);
    chk({tag, "_sat_v"}, {7'd0, s_v}, 8'd1);
    chk({tag, "_sat_ovf"}, {7'd0, s_o}, {7'd0, eovf});
    chk({tag, "_wrap_c"}, w_c, ec_wrap);
    chk({tag, "_wrap_ovf"}, {7'd0, w_o}, {7'd0, eovf});
    chk({tag, "_rnd_c"}, r_c, ec_rnd);
  endtask

  initial begin
    #2;
    chk("rst_c", s_c, 8'h00);
    chk("rst_v", {7'd0, s_v}, 8'd0);
    chk("rst_ovf", {7'd0, s_o}, 8'd0);
    chk("rst_sticky", {7'd0, s_st}, 8'd0);
    step();
    rst = 1'b0;
    step();

    run("basic",   8'h18, 8'h20, 8'h30, 1'b0, 8'h30, 8'h30);
    chk("basic_sticky", {7'd0, s_st}, 8'd0);
    run("maxmax",  8'h7F, 8'h7F, 8'h7F, 1'b1, 8'hF0, 8'h7F);
    chk("maxmax_sticky", {7'd0, s_st}, 8'd1);
    chk("maxmax_wsticky", {7'd0, w_st}, 8'd1);
    run("minmin",  8'h80, 8'h80, 8'h7F, 1'b1, 8'h00, 8'h7F);
    // -8.0 * 7.9375 = -63.5 is below -8.0, so it clamps to the minimum
    run("minmax",  8'h80, 8'h7F, 8'h80, 1'b1, 8'h08, 8'h80);
    run("rnd_pos", 8'h01, 8'h08, 8'h00, 1'b0, 8'h00, 8'h01);
    run("rnd_neg", 8'hFF, 8'h08, 8'hFF, 1'b0, 8'hFF, 8'h00);

    // Clear with en low and an idle output stage
    step();
    chk("idle_v", {7'd0, s_v}, 8'd0);
    en = 1'b0; clr_ovf = 1'b1;
    step();
    en = 1'b1; clr_ovf = 1'b0;
    chk("clr_en0_sticky", {7'd0, s_st}, 8'd0);

    // Overflow output landing on the same edge as a clear: set wins
    a = 8'h7F; b = 8'h7F; in_valid = 1'b1;
    step();
    in_valid = 1'b0; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("setwins_ovf", {7'd0, s_o}, 8'd1);
    chk("setwins_sticky", {7'd0, s_st}, 8'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_sticky", {7'd0, s_st}, 8'd0);
    step();

    // Stream of four with a three-cycle stall
    a = 8'h10; b = 8'h10; in_valid = 1'b1;
    step();
    a = 8'h20; b = 8'h18;
    step();
    chk("s0_c", s_c, 8'h10);
    chk("s0_v", {7'd0, s_v}, 8'd1);
    en = 1'b0; a = 8'hF0; b = 8'h20;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_c", s_c, 8'h10);
      chk("stall_v", {7'd0, s_v}, 8'd1);
    end
    en = 1'b1;
    step();
    chk("s1_c", s_c, 8'h30);
    a = 8'h11; b = 8'h11;
    step();
    chk("s2_c", s_c, 8'hE0);
    chk("s2_v", {7'd0, s_v}, 8'd1);
    in_valid = 1'b0;
    step();
    chk("s3_c", s_c, 8'h12);
    chk("s3_v", {7'd0, s_v}, 8'd1);
    step();
    chk("s_end_v", {7'd0, s_v}, 8'd0);

    // Reset mid-stream
    a = 8'h7F; b = 8'h7F; in_valid = 1'b1;
    step();
    a = 8'h18; b = 8'h20;
    step();
    chk("pre_rst_sticky", {7'd0, s_st}, 8'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_c", s_c, 8'h00);
    chk("rst_mid_v", {7'd0, s_v}, 8'd0);
    chk("rst_mid_ovf", {7'd0, s_o}, 8'd0);
    chk("rst_mid_sticky", {7'd0, s_st}, 8'd0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("post_rst_v1", {7'd0, s_v}, 8'd0);
    step();
    chk("post_rst_v2", {7'd0, s_v}, 8'd0);
    a = 8'h18; b = 8'h20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_lat", {7'd0, s_v}, 8'd0);
    step();
    chk("post_rst_c", s_c, 8'h30);
    chk("post_rst_v", {7'd0, s_v}, 8'd1);
    chk("post_rst_sticky", {7'd0, s_st}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
